// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch buffer entry layout for the fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = '0;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = '0;
  localparam logic [ADDR_W-1:0]  PC_INCR          = 32'd4;

  // One buffered fetch: the instruction word and the address after it.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for fetched instructions and request address tags.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking with synchronous flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers responses
// and drives the IF/ID register, dropping wrong-path responses after a redirect.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic               ImemReqValid,
  input  logic               ImemReqReady,
  output logic [ADDR_W-1:0]  ImemReqAddr,
  input  logic               ImemRspValid,
  input  logic [INSTR_W-1:0] ImemRspData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectTarget,
  input  logic               Stall,
  output logic               IfIdValid,
  output logic [INSTR_W-1:0] IfIdInstr,
  output logic [ADDR_W-1:0]  IfIdPCPlus4
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     data_count;
  logic [CW-1:0]     tag_count;
  logic              data_empty, data_full, tag_empty, tag_full;
  logic              data_push, data_pop;
  logic              accept, rsp_keep, rsp_drop, loadable;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      data_head;
  fetch_entry_t      rsp_entry;
  logic              unused_ok;

  assign ImemReqValid = Rst_n && !Redirect &&
                        (({1'b0, inflight} + {1'b0, data_count}) < (CW+1)'(DEPTH));
  assign ImemReqAddr  = pc;
  assign accept       = ImemReqValid && ImemReqReady;
  assign rsp_drop     = ImemRspValid && (discard != '0);
  assign rsp_keep     = ImemRspValid && (discard == '0) && !Redirect;
  assign loadable     = !IfIdValid || !Stall;
  assign rsp_entry    = '{instr: ImemRspData, pc_plus4: tag_head + PC_INCR};
  assign data_pop     = loadable && !data_empty && !Redirect;
  // A kept response skips the buffer only when IF/ID takes it directly this cycle.
  assign data_push    = rsp_keep && !(loadable && data_empty);

  assign unused_ok = &{1'b0, tag_count, tag_empty, tag_full, data_full, RedirectTarget[1:0]};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_tag_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clear     (Redirect),
    .push      (accept),
    .pop       (rsp_keep),
    .push_data (pc),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W + ADDR_W)) u_data_fifo (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clear     (Redirect),
    .push      (data_push),
    .pop       (data_pop),
    .push_data (rsp_entry),
    .head      (data_head),
    .count     (data_count),
    .empty     (data_empty),
    .full      (data_full)
  );

  // Program counter: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        pc <= RESET_PC;
    else if (Redirect) pc <= {RedirectTarget[ADDR_W-1:2], 2'b00};
    else if (accept)   pc <= pc + PC_INCR;
  end

  // Outstanding and to-be-dropped response counters.
  // On redirect every response still pending after this cycle becomes a discard;
  // discard never exceeds inflight, so the new value subsumes any earlier discards.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inflight <= '0;
      discard  <= '0;
    end else if (Redirect) begin
      inflight <= inflight - CW'(ImemRspValid);
      discard  <= inflight - CW'(ImemRspValid);
    end else begin
      inflight <= inflight + CW'(accept) - CW'(ImemRspValid);
      if (rsp_drop) discard <= discard - 1'b1;
    end
  end

  // IF/ID register: load buffer head first, else bypass a fresh response, else bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      IfIdValid   <= 1'b0;
      IfIdInstr   <= NOP_INSTR;
      IfIdPCPlus4 <= '0;
    end else if (Redirect) begin
      IfIdValid <= 1'b0;
    end else if (loadable) begin
      if (!data_empty) begin
        IfIdValid   <= 1'b1;
        IfIdInstr   <= data_head.instr;
        IfIdPCPlus4 <= data_head.pc_plus4;
      end else if (rsp_keep) begin
        IfIdValid   <= 1'b1;
        IfIdInstr   <= rsp_entry.instr;
        IfIdPCPlus4 <= rsp_entry.pc_plus4;
      end else begin
        IfIdValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table with a 1-cycle address-as-data memory.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemReqAddr;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Stall;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPCPlus4;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  int          mq_cyc[$];

  typedef struct {
    logic        ready;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        mem;
    logic        ev;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] ei;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl[26];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .ImemReqValid   (ImemReqValid),
    .ImemReqReady   (ImemReqReady),
    .ImemReqAddr    (ImemReqAddr),
    .ImemRspValid   (ImemRspValid),
    .ImemRspData    (ImemRspData),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Stall          (Stall),
    .IfIdValid      (IfIdValid),
    .IfIdInstr      (IfIdInstr),
    .IfIdPCPlus4    (IfIdPCPlus4)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic rdy, input logic stl, input logic rd,
                              input logic [31:0] tgt, input logic mem,
                              input logic ev, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.ready = rdy; v.stall = stl; v.redirect = rd; v.target = tgt; v.mem = mem;
    v.ev = ev; v.ea = ea; v.eiv = eiv; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input int k, input vec_t v);
    logic        acc;
    logic [31:0] a;
    @(negedge Clk);
    ImemReqReady   = v.ready;
    Stall          = v.stall;
    Redirect       = v.redirect;
    RedirectTarget = v.target;
    if (v.mem && mq.size() > 0 && mq_cyc[0] < k) begin
      ImemRspValid = 1'b1;
      ImemRspData  = mq.pop_front();
      void'(mq_cyc.pop_front());
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData  = '0;
    end
    #1;
    chk($sformatf("row%0d req_valid", k), 32'(ImemReqValid), 32'(v.ev));
    chk($sformatf("row%0d req_addr", k), ImemReqAddr, v.ea);
    chk($sformatf("row%0d ifid_valid", k), 32'(IfIdValid), 32'(v.eiv));
    if (v.eiv) begin
      chk($sformatf("row%0d ifid_instr", k), IfIdInstr, v.ei);
      chk($sformatf("row%0d ifid_pc4", k), IfIdPCPlus4, v.ep);
    end
    acc = ImemReqValid && ImemReqReady;
    a   = ImemReqAddr;
    @(posedge Clk);
    if (acc) begin
      mq.push_back(a);
      mq_cyc.push_back(k);
    end
  endtask

  initial begin
    //              rdy stl rd target        mem ev  addr          eiv instr         pc+4
    tbl[0]  = mk(1, 0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0,         32'h0);
    tbl[2]  = mk(1, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0,         32'h4);
    tbl[3]  = mk(1, 0, 0, 32'h0,         1, 1, 32'hC,         1, 32'h4,         32'h8);
    tbl[4]  = mk(1, 1, 0, 32'h0,         1, 1, 32'h10,        1, 32'h8,         32'hC);
    tbl[5]  = mk(1, 1, 0, 32'h0,         1, 0, 32'h14,        1, 32'h8,         32'hC);
    tbl[6]  = mk(1, 1, 0, 32'h0,         1, 0, 32'h14,        1, 32'h8,         32'hC);
    tbl[7]  = mk(1, 1, 0, 32'h0,         1, 0, 32'h14,        1, 32'h8,         32'hC);
    tbl[8]  = mk(1, 0, 0, 32'h0,         1, 0, 32'h14,        1, 32'h8,         32'hC);
    tbl[9]  = mk(1, 0, 0, 32'h0,         1, 1, 32'h14,        1, 32'hC,         32'h10);
    tbl[10] = mk(1, 0, 0, 32'h0,         1, 1, 32'h18,        1, 32'h10,        32'h14);
    tbl[11] = mk(0, 0, 0, 32'h0,         1, 1, 32'h1C,        1, 32'h14,        32'h18);
    tbl[12] = mk(0, 0, 0, 32'h0,         1, 1, 32'h1C,        1, 32'h18,        32'h1C);
    tbl[13] = mk(0, 0, 0, 32'h0,         1, 1, 32'h1C,        0, 32'h0,         32'h0);
    tbl[14] = mk(1, 0, 0, 32'h0,         1, 1, 32'h1C,        0, 32'h0,         32'h0);
    tbl[15] = mk(1, 0, 0, 32'h0,         0, 1, 32'h20,        0, 32'h0,         32'h0);
    tbl[16] = mk(1, 0, 1, 32'h103,       0, 0, 32'h24,        0, 32'h0,         32'h0);
    tbl[17] = mk(1, 0, 0, 32'h0,         1, 0, 32'h100,       0, 32'h0,         32'h0);
    tbl[18] = mk(1, 0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         32'h0);
    tbl[19] = mk(1, 0, 0, 32'h0,         1, 1, 32'h104,       0, 32'h0,         32'h0);
    tbl[20] = mk(1, 0, 0, 32'h0,         1, 1, 32'h108,       1, 32'h100,       32'h104);
    tbl[21] = mk(1, 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h10C,       1, 32'h104,       32'h108);
    tbl[22] = mk(1, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    tbl[23] = mk(1, 0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0);
    tbl[24] = mk(1, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'hFFFF_FFFC, 32'h0);
    tbl[25] = mk(0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0,         32'h4);

    Rst_n          = 1'b0;
    ImemReqReady   = 1'b0;
    ImemRspValid   = 1'b0;
    ImemRspData    = '0;
    Redirect       = 1'b0;
    RedirectTarget = '0;
    Stall          = 1'b0;

    // Values held during reset.
    repeat (2) @(negedge Clk);
    chk("reset req_valid", 32'(ImemReqValid), 32'h0);
    chk("reset req_addr", ImemReqAddr, 32'h0);
    chk("reset ifid_valid", 32'(IfIdValid), 32'h0);
    chk("reset ifid_instr", IfIdInstr, 32'h0);
    chk("reset ifid_pc4", IfIdPCPlus4, 32'h0);
    Rst_n = 1'b1;
    #1;
    chk("release req_valid", 32'(ImemReqValid), 32'h1);
    @(posedge Clk);

    for (int k = 0; k < 26; k++) run_row(k, tbl[k]);

    // Asynchronous reset pulse with a request in flight and IF/ID valid.
    @(negedge Clk);
    ImemReqReady = 1'b1;
    ImemRspValid = 1'b0;
    #1;
    chk("prereset ifid_valid", 32'(IfIdValid), 32'h1);
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midreset req_valid", 32'(ImemReqValid), 32'h0);
    chk("midreset req_addr", ImemReqAddr, 32'h0);
    chk("midreset ifid_valid", 32'(IfIdValid), 32'h0);
    chk("midreset ifid_instr", IfIdInstr, 32'h0);
    chk("midreset ifid_pc4", IfIdPCPlus4, 32'h0);
    mq.delete();
    mq_cyc.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("restart req_valid", 32'(ImemReqValid), 32'h1);
    chk("restart req_addr", ImemReqAddr, 32'h0);
    @(posedge Clk);
    @(negedge Clk);
    ImemRspValid = 1'b1;
    ImemRspData  = 32'h0;
    #1;
    chk("restart next_addr", ImemReqAddr, 32'h4);
    ImemReqReady = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    ImemRspValid = 1'b0;
    #1;
    chk("restart ifid_valid", 32'(IfIdValid), 32'h1);
    chk("restart ifid_pc4", IfIdPCPlus4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
